// File: rtl/s3g_tx_multi.sv
// s3g_tx_multi: S3G packet transmitter with N_SINKS byte-serial sinks.
//
// Frames a latched payload as 0xD5, length, payload bytes, CRC-8 and presents
// each byte to every sink on a shared tx_data/tx_wr pair. The next byte is sent
// only once every sink enabled in the latched sink_en mask has pulsed tx_done.
//
// Optional feature: define S3G_TX_TIMEOUT_EN to build a per-byte wait counter.
// Without it, timeout is tied 0 and the block waits for acks indefinitely.
//
// Parameters:
//   N_SINKS        number of downstream byte sinks (1..8)
//   MAX_PAYLOAD    payload buffer depth in bytes (1..255)
//   TIMEOUT_CYCLES per-byte sink wait limit in clocks (S3G_TX_TIMEOUT_EN only, >= 2)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   packet_wr    one-cycle start strobe
//   payload_len  payload byte count, sampled on packet_wr
//   payload      payload bytes, byte i at [8*i+7:8*i], sampled on packet_wr
//   sink_en      mask of sinks that must acknowledge, sampled on packet_wr
//   tx_done      per-sink one-cycle "byte sent" pulse
//   tx_data      byte to sinks, held stable between strobes
//   tx_wr        one-cycle byte strobe common to all sinks
//   busy         packet in progress
//   pkt_done     one-cycle pulse when the CRC byte is acknowledged
//   len_err      one-cycle pulse when packet_wr is rejected (length too large)
//   timeout      one-cycle pulse on sink wait timeout
module s3g_tx_multi #(
    parameter int unsigned N_SINKS        = 2,
    parameter int unsigned MAX_PAYLOAD    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     packet_wr,
    input  logic [7:0]               payload_len,
    input  logic [8*MAX_PAYLOAD-1:0] payload,
    input  logic [N_SINKS-1:0]       sink_en,
    input  logic [N_SINKS-1:0]       tx_done,
    output logic [7:0]               tx_data,
    output logic                     tx_wr,
    output logic                     busy,
    output logic                     pkt_done,
    output logic                     len_err,
    output logic                     timeout
);

    localparam int unsigned IDX_W   = $clog2(MAX_PAYLOAD + 1);
    localparam logic [7:0]  MaxLen  = 8'(MAX_PAYLOAD);
    localparam logic [7:0]  HdrByte = 8'hD5;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLen,
        StData,
        StCrc,
        StFin
    } state_e;

    state_e                   state_q;
    logic [8*MAX_PAYLOAD-1:0] payload_q;
    logic [7:0]               len_q;
    logic [N_SINKS-1:0]       en_q;
    logic [N_SINKS-1:0]       pending_q;
    logic [7:0]               crc_q;
    logic [IDX_W-1:0]         idx_q;

    // Dallas/Maxim CRC-8, reflected polynomial 0x8C, one byte LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    logic [7:0] idx_ext;
    logic [7:0] cur_byte;
    logic       waiting;
    logic       byte_done;
    logic       more_data;
    logic       to_hit;

    assign idx_ext = 8'(idx_q);

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
            if (idx_ext == 8'(i)) begin
                cur_byte = payload_q[8*i +: 8];
            end
        end
    end

    assign waiting   = state_q inside {StHdr, StLen, StData, StCrc};
    // pending_q still holds the previous byte's (empty) mask during the strobe
    // cycle, so completion is only recognised from the cycle after tx_wr.
    assign byte_done = waiting && !tx_wr && (pending_q == '0);
    assign more_data = idx_ext < len_q;

`ifdef S3G_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Loaded with 1 in the strobe cycle, so the count equals cycles since tx_wr;
    // firing at TIMEOUT_CYCLES-1 puts the timeout pulse TIMEOUT_CYCLES after tx_wr.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (tx_wr) begin
            to_cnt_q <= TO_W'(1);
        end else if (waiting && (pending_q != '0)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign to_hit = waiting && !tx_wr && (pending_q != '0) &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            payload_q <= '0;
            len_q     <= '0;
            en_q      <= '0;
            pending_q <= '0;
            crc_q     <= '0;
            idx_q     <= '0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            len_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tx_wr    <= 1'b0;
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
            timeout  <= 1'b0;

            // Acks arriving in the strobe cycle itself are discarded.
            if (tx_wr) begin
                pending_q <= en_q;
            end else begin
                pending_q <= pending_q & ~(tx_done & en_q);
            end

            if (to_hit) begin
                timeout   <= 1'b1;
                busy      <= 1'b0;
                pending_q <= '0;
                state_q   <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (packet_wr) begin
                            if (payload_len > MaxLen) begin
                                len_err <= 1'b1;
                            end else begin
                                payload_q <= payload;
                                len_q     <= payload_len;
                                en_q      <= sink_en;
                                tx_data   <= HdrByte;
                                tx_wr     <= 1'b1;
                                busy      <= 1'b1;
                                state_q   <= StHdr;
                            end
                        end
                    end
                    StHdr: begin
                        if (byte_done) begin
                            tx_data <= len_q;
                            tx_wr   <= 1'b1;
                            crc_q   <= '0;
                            idx_q   <= '0;
                            state_q <= StLen;
                        end
                    end
                    StLen, StData: begin
                        if (byte_done) begin
                            tx_wr <= 1'b1;
                            if (more_data) begin
                                tx_data <= cur_byte;
                                crc_q   <= crc8_byte(crc_q, cur_byte);
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= StData;
                            end else begin
                                tx_data <= crc_q;
                                state_q <= StCrc;
                            end
                        end
                    end
                    StCrc: begin
                        if (byte_done) begin
                            pkt_done <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StFin;
                        end
                    end
                    StFin: begin
                        // One dead cycle: a packet_wr here is dropped.
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_s3g_tx_multi.sv
// Self-checking bench for s3g_tx_multi: directed and randomized packets with
// per-sink ack delays, checked against a frame/CRC/timing reference model.
module tb_s3g_tx_multi;

    localparam int N    = 2;
    localparam int MAXP = 32;
    localparam int TO   = 16;

    logic             clk         = 1'b0;
    logic             rst         = 1'b1;
    logic             packet_wr   = 1'b0;
    logic [7:0]       payload_len = '0;
    logic [8*MAXP-1:0] payload    = '0;
    logic [N-1:0]     sink_en     = '0;
    logic [N-1:0]     tx_done     = '0;
    logic [7:0]       tx_data;
    logic             tx_wr;
    logic             busy;
    logic             pkt_done;
    logic             len_err;
    logic             timeout;

    always #5 clk = ~clk;

    s3g_tx_multi #(
        .N_SINKS       (N),
        .MAX_PAYLOAD   (MAXP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .packet_wr  (packet_wr),
        .payload_len(payload_len),
        .payload    (payload),
        .sink_en    (sink_en),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .len_err    (len_err),
        .timeout    (timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] got_b[$];
    int         got_c[$];
    int pd_cnt = 0, pd_cyc = 0, pd_busy_bad = 0, le_cnt = 0;
    int to_cnt = 0, to_cyc = 0, stab_err = 0, busy_cyc = 0;
    logic [7:0] last_b = '0;

    int         ack_dly[N] = '{default: 0};
    int         rcnt[N]    = '{default: 0};
    bit         spur       = 1'b0;
    bit         noise      = 1'b0;
    logic [N-1:0] cur_en   = '0;
    logic [7:0] pl[MAXP];

    // Monitor: samples DUT outputs mid-cycle.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (busy === 1'b1) busy_cyc++;
        if (tx_wr === 1'b1) begin
            got_b.push_back(tx_data);
            got_c.push_back(cyc);
            last_b = tx_data;
        end else if (busy === 1'b1 && tx_data !== last_b) begin
            stab_err++;
        end
        if (pkt_done === 1'b1) begin
            pd_cnt++;
            pd_cyc = cyc;
            if (busy !== 1'b0) pd_busy_bad++;
        end
        if (len_err === 1'b1) le_cnt++;
        if (timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    // Sink model: sink i pulses tx_done ack_dly[i] cycles after each tx_wr
    // (0 = never). Optional spurious acks in the strobe cycle and random
    // pulses on sinks outside the packet's mask.
    initial forever begin
        logic [N-1:0] d;
        @(negedge clk);
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                rcnt[i] = 0;
            end else if (rcnt[i] > 0) begin
                rcnt[i]--;
                if (rcnt[i] == 0) d[i] = 1'b1;
            end
        end
        if (noise) d = d | (N'($urandom) & ~cur_en);
        if (tx_wr === 1'b1 && !rst) begin
            for (int i = 0; i < N; i++) rcnt[i] = ack_dly[i];
            if (spur) d = '1;
        end
        tx_done = d;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC-8/MAXIM as a bit-serial LFSR, LSB of each byte first.
    function automatic logic [7:0] ref_crc(input int len);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < len; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pl[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 8'h8C;
            end
        end
        return c;
    endfunction

    // Spacing between strobes: slowest enabled sink's delay plus two cycles.
    function automatic int exp_gap();
        int m;
        m = 0;
        for (int i = 0; i < N; i++) begin
            if (cur_en[i] && ack_dly[i] > m) m = ack_dly[i];
        end
        return m + 2;
    endfunction

    task automatic randomize_pl();
        for (int k = 0; k < MAXP; k++) pl[k] = 8'($urandom);
    endtask

    task automatic send(input int len, input logic [N-1:0] en);
        step();
        got_b.delete();
        got_c.delete();
        cur_en = en;
        for (int k = 0; k < MAXP; k++) payload[8*k +: 8] = pl[k];
        payload_len = 8'(len);
        sink_en     = en;
        packet_wr   = 1'b1;
        step();
        packet_wr   = 1'b0;
    endtask

    task automatic run_pkt(input string name, input int len, input logic [N-1:0] en,
                           input int ovl_at, input bit fin_wr);
        logic [7:0] e[$];
        int pd0, gap, budget, n, m;
        pd0 = pd_cnt;
        send(len, en);
        gap = exp_gap();
        e.push_back(8'hD5);
        e.push_back(8'(len));
        for (int k = 0; k < len; k++) e.push_back(pl[k]);
        e.push_back(ref_crc(len));
        budget = (len + 3) * gap + 20;
        n = 0;
        while (pd_cnt == pd0 && n < budget) begin
            if (n == ovl_at) begin
                for (int k = 0; k < MAXP; k++) payload[8*k +: 8] = 8'($urandom);
                payload_len = 8'($urandom_range(0, MAXP));
                sink_en     = ~en;
                packet_wr   = 1'b1;
            end else begin
                packet_wr = 1'b0;
            end
            step();
            n++;
        end
        packet_wr = 1'b0;
        chk({name, "_done"}, pd_cnt - pd0, 1);
        if (fin_wr) begin
            payload_len = 8'd3;
            sink_en     = en;
            packet_wr   = 1'b1;
            step();
            packet_wr = 1'b0;
            repeat (6) step();
            chk({name, "_fin_wr_bytes"}, got_b.size(), e.size());
            chk({name, "_fin_wr_busy"}, busy, 1'b0);
        end
        chk({name, "_nbytes"}, got_b.size(), e.size());
        m = (got_b.size() < e.size()) ? got_b.size() : e.size();
        for (int k = 0; k < m; k++) chk($sformatf("%s_byte%0d", name, k), got_b[k], e[k]);
        for (int k = 1; k < got_c.size(); k++) begin
            chk($sformatf("%s_gap%0d", name, k), got_c[k] - got_c[k-1], gap);
        end
        if (got_c.size() > 0) chk({name, "_pd_lat"}, pd_cyc - got_c[got_c.size()-1], gap);
    endtask

    initial begin
        int le0, b0, pd0, to0, n;

        // Reset state
        step();
        step();
        chk("rst_tx_wr", tx_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0;
        step();

        // Single one-byte packet, both sinks ack 3 cycles after each strobe
        pl[0] = 8'h01;
        ack_dly = '{3, 3};
        run_pkt("single", 1, 2'b11, -1, 1'b0);
        if (got_b.size() == 4) chk("single_crc_5e", got_b[3], 8'h5E);

        // Skewed acks plus acks coinciding with every strobe
        randomize_pl();
        ack_dly = '{2, 9};
        spur = 1'b1;
        run_pkt("skew", 4, 2'b11, -1, 1'b0);
        spur = 1'b0;

        // Sink1 masked off and silent; random chatter on masked sinks
        randomize_pl();
        ack_dly = '{4, 0};
        noise = 1'b1;
        run_pkt("mask", 3, 2'b01, -1, 1'b0);

        // Zero-length frame
        ack_dly = '{2, 5};
        run_pkt("len0", 0, 2'b11, -1, 1'b0);
        if (got_b.size() == 3) chk("len0_crc", got_b[2], 8'h00);

        // Full buffer, bytes 0..31
        for (int k = 0; k < MAXP; k++) pl[k] = 8'(k);
        ack_dly = '{1, 2};
        run_pkt("max", MAXP, 2'b11, -1, 1'b0);

        // No sinks enabled
        randomize_pl();
        ack_dly = '{0, 0};
        run_pkt("noen", 2, 2'b00, -1, 1'b0);
        noise = 1'b0;

        // packet_wr mid-packet and in the dead cycle after pkt_done
        randomize_pl();
        ack_dly = '{3, 3};
        run_pkt("ovl", 5, 2'b11, 4, 1'b1);

        // Oversized lengths are rejected
        for (int j = 0; j < 2; j++) begin
            le0 = le_cnt;
            b0  = busy_cyc;
            send((j == 0) ? MAXP + 1 : 255, 2'b11);
            repeat (4) step();
            chk($sformatf("rej%0d_len_err", j), le_cnt - le0, 1);
            chk($sformatf("rej%0d_no_tx", j), got_b.size(), 0);
            chk($sformatf("rej%0d_busy", j), busy_cyc - b0, 0);
        end

        // Randomized packets
        for (int r = 0; r < 5; r++) begin
            logic [N-1:0] en;
            randomize_pl();
            en = N'($urandom);
            for (int i = 0; i < N; i++) ack_dly[i] = en[i] ? int'($urandom_range(1, 9)) : 0;
            noise = 1'b1;
            spur  = 1'($urandom);
            run_pkt($sformatf("rnd%0d", r), int'($urandom_range(0, MAXP)), en, -1, 1'b0);
        end
        noise = 1'b0;
        spur  = 1'b0;

        // Reset while DATA byte 3 is outstanding
        randomize_pl();
        ack_dly = '{2, 3};
        send(6, 2'b11);
        n = 0;
        while (got_b.size() < 6 && n < 200) begin
            step();
            n++;
        end
        chk("rstmid_reach", got_b.size(), 6);
        pd0 = pd_cnt;
        rst = 1'b1;
        step();
        chk("rstmid_tx_wr", tx_wr, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        step();
        chk("rstmid_no_done", pd_cnt - pd0, 0);
        randomize_pl();
        run_pkt("after_rst", 6, 2'b11, -1, 1'b0);

        // Sink1 never acks
        ack_dly = '{3, 0};
        to0 = to_cnt;
        pd0 = pd_cnt;
        send(2, 2'b11);
        repeat (40) step();
        chk("to_nbytes", got_b.size(), 1);
        chk("to_no_done", pd_cnt - pd0, 0);
`ifdef S3G_TX_TIMEOUT_EN
        chk("to_pulse", to_cnt - to0, 1);
        if (got_c.size() > 0) chk("to_lat", to_cyc - got_c[0], TO);
        chk("to_busy", busy, 1'b0);
`else
        chk("to_pulse", to_cnt - to0, 0);
        chk("to_busy", busy, 1'b1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        chk("tx_data_stable", stab_err, 0);
        chk("busy_low_at_done", pd_busy_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s3g_tx_multi.md
Name: s3g_tx_multi

Overview:
- Parametrised S3G packet transmitter; successor to the fixed 16-byte, 2-sink transmitter.
- Frames a payload as 0xD5, length, payload bytes, CRC-8.
- Presents each byte to N_SINKS byte-serial sinks (UARTs, debug taps) and waits for every enabled sink to report completion before sending the next byte.
- Sits between the command-response builder and the UART TX instances.

Parameters:
- N_SINKS, 2, number of downstream byte sinks (1..8).
- MAX_PAYLOAD, 32, payload buffer depth in bytes (1..255).
- TIMEOUT_CYCLES, 65535, per-byte sink wait limit in clocks; used only with S3G_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- packet_wr  in  1  start strobe, one cycle.
- payload_len  in  8  payload byte count, sampled on packet_wr.
- payload  in  8*MAX_PAYLOAD  payload bytes; byte i = payload[8*i+7:8*i]; sampled on packet_wr.
- sink_en  in  N_SINKS  mask of sinks that must acknowledge; sampled on packet_wr.
- tx_done  in  N_SINKS  per-sink one-cycle "byte sent" pulse.
- tx_data  out  8  byte to sinks.
- tx_wr  out  1  one-cycle byte strobe, common to all sinks.
- busy  out  1  high from the cycle after an accepted packet_wr until the packet ends.
- pkt_done  out  1  one-cycle pulse when the CRC byte is acknowledged.
- len_err  out  1  one-cycle pulse when packet_wr is rejected because payload_len > MAX_PAYLOAD.
- timeout  out  1  one-cycle pulse on sink wait timeout; constant 0 unless S3G_TX_TIMEOUT_EN.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending mask 0, CRC 0. Reset mid-packet abandons the packet immediately; no pkt_done.
- FSM states: IDLE, HDR, LEN, DATA, CRC, FIN.
- IDLE, on packet_wr:
  - payload_len <= MAX_PAYLOAD: latch payload, length and sink_en. Next edge sets tx_data=0xD5, tx_wr=1, busy=1, and enters HDR.
  - payload_len > MAX_PAYLOAD: pulse len_err on the next cycle, stay IDLE, busy stays 0.
- packet_wr while busy: ignored; latched data unchanged.
- Ack tracking, on every tx_wr cycle:
  - pending <= latched sink_en.
  - tx_done pulses in the tx_wr cycle itself are ignored.
  - In later cycles, tx_done[i] clears pending[i]; tx_done for sinks not enabled is ignored.
  - A byte is complete in the first cycle in which pending==0.
  - sink_en==0 makes each byte complete in the cycle after its tx_wr.
- Ack latency: if the last required tx_done is high in cycle t, the next tx_wr is high in cycle t+2.
- Byte sequence:
  - HDR complete: send the length byte, clear the CRC, index=0, enter LEN.
  - LEN/DATA complete with index < len: send byte[index], update CRC, index+1, enter or stay in DATA.
  - Complete with index == len: send the CRC byte, enter CRC.
  - CRC complete: pkt_done=1 and busy=0 on the same edge, enter FIN, then return to IDLE the next cycle. packet_wr in FIN is ignored.
- Length 0: frame is D5, 00, CRC 00.
- CRC: Dallas/Maxim CRC-8 (poly x^8+x^5+x^4+1, reflected 0x8C), init 0x00, computed over payload bytes only. Length and header bytes are excluded.
- tx_data holds its value between tx_wr strobes and is stable for the whole byte.
- Index counter width: clog2(MAX_PAYLOAD+1).
- Only one tx_wr is outstanding at any time.

Optional Feature:
- Macro: S3G_TX_TIMEOUT_EN.
- Defined:
  - A counter starts at each tx_wr and counts cycles while pending != 0.
  - On reaching TIMEOUT_CYCLES without completion: pulse timeout, drop busy, return to IDLE; no pkt_done.
  - The counter resets on every tx_wr.
- Not defined: no counter is built, timeout is tied 0, and the block waits indefinitely for acks.

Test Plan:
- Single packet: N_SINKS=2, sink_en=11, len=1, byte0=0x01, both sinks ack 3 cycles after each tx_wr -> tx_data sequence D5, 01, 01, 5E; pkt_done pulses once; busy falls with pkt_done.
- Skewed acks: sink0 acks after 2 cycles, sink1 after 9 cycles -> each next tx_wr is exactly 2 cycles after sink1's tx_done; a tx_done coinciding with tx_wr does not advance the FSM.
- Masking and edge lengths:
  - sink_en=01 with sink1 never acking -> packet completes normally.
  - len=0 -> D5, 00, 00.
  - len=MAX_PAYLOAD=32, bytes 0..31 -> 35 bytes total, last byte is the matching CRC.
- Rejection and overlap:
  - payload_len=33 -> len_err pulse, no tx_wr, busy stays 0.
  - packet_wr mid-packet with different payload -> the original frame is sent unchanged.
- Reset mid-packet: rst asserted during DATA byte 3 -> next cycle tx_wr=0, busy=0, tx_data=0; a new packet_wr afterwards produces a correct full frame.
- With S3G_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16: sink1 never acks -> timeout pulses 16 cycles after tx_wr, busy drops, no pkt_done. Without the macro -> timeout stays 0 and busy stays 1.
